// File: rtl/shift_serializer_arb.sv
// shift_serializer_arb: two-requester round-robin owner of a WIDTH-bit
// MSB-first serializer. Grants, loads, shifts WIDTH bits, then pulses done
// to the owner.
// Optional feature macro: SHIFT_PARITY_EN (appends an even-parity bit per word).
module shift_serializer_arb #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   output logic             gnt0,
   output logic             done0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt1,
   output logic             done1,
   output logic             sdo,
   output logic             sdo_valid,
   output logic             sdo_owner,
   output logic             busy
);

`ifdef SHIFT_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   localparam logic [4:0] CNT_LAST = 5'(WIDTH);

   state_t           state, state_d;
   logic [WIDTH-1:0] shreg, shreg_d;
   logic [4:0]       cnt, cnt_d;
   logic             last, last_d;
`ifdef SHIFT_PARITY_EN
   logic             par, par_d;
`endif
   logic             gnt0_d, gnt1_d, done0_d, done1_d;
   logic             sdo_d, sdo_valid_d, sdo_owner_d;
   logic             sel;
   logic [WIDTH-1:0] data_sel;

   // Round-robin pick: on contention favour the requester not served last.
   always_comb begin
      sel      = (req0 && req1) ? ~last : req1;
      data_sel = sel ? data1 : data0;
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d     = state;
      shreg_d     = shreg;
      cnt_d       = cnt;
      last_d      = last;
`ifdef SHIFT_PARITY_EN
      par_d       = par;
`endif
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      sdo_d       = 1'b0;
      sdo_valid_d = 1'b0;
      sdo_owner_d = sdo_owner;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_d     = SHIFT;
               shreg_d     = data_sel << 1;
               sdo_d       = data_sel[WIDTH-1];
               sdo_valid_d = 1'b1;
               gnt0_d      = ~sel;
               gnt1_d      = sel;
               sdo_owner_d = sel;
               last_d      = sel;
               cnt_d       = 5'd1;
`ifdef SHIFT_PARITY_EN
               par_d       = ^data_sel;
`endif
            end
         end
         SHIFT: begin
            if (cnt < CNT_LAST) begin
               sdo_d       = shreg[WIDTH-1];
               sdo_valid_d = 1'b1;
               shreg_d     = shreg << 1;
               cnt_d       = cnt + 5'd1;
            end else begin
`ifdef SHIFT_PARITY_EN
               state_d     = PAR;
               sdo_d       = par;
               sdo_valid_d = 1'b1;
`else
               state_d     = DONE;
               done0_d     = ~sdo_owner;
               done1_d     = sdo_owner;
`endif
            end
         end
`ifdef SHIFT_PARITY_EN
         PAR: begin
            state_d = DONE;
            done0_d = ~sdo_owner;
            done1_d = sdo_owner;
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         last      <= 1'b1;
`ifdef SHIFT_PARITY_EN
         par       <= 1'b0;
`endif
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         sdo       <= 1'b0;
         sdo_valid <= 1'b0;
         sdo_owner <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_d;
         shreg     <= shreg_d;
         cnt       <= cnt_d;
         last      <= last_d;
`ifdef SHIFT_PARITY_EN
         par       <= par_d;
`endif
         gnt0      <= gnt0_d;
         gnt1      <= gnt1_d;
         done0     <= done0_d;
         done1     <= done1_d;
         sdo       <= sdo_d;
         sdo_valid <= sdo_valid_d;
         sdo_owner <= sdo_owner_d;
         busy      <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_shift_serializer_arb.sv
// Directed testbench for shift_serializer_arb (WIDTH=8); honours SHIFT_PARITY_EN.
module tb_shift_serializer_arb;

   localparam int W = 8;
`ifdef SHIFT_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1;
   logic [W-1:0] data0, data1;
   logic         gnt0, done0, gnt1, done1;
   logic         sdo, sdo_valid, sdo_owner, busy;

   int vectors = 0;
   int errs    = 0;

   shift_serializer_arb #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .data0     (data0),
      .gnt0      (gnt0),
      .done0     (done0),
      .req1      (req1),
      .data1     (data1),
      .gnt1      (gnt1),
      .done1     (done1),
      .sdo       (sdo),
      .sdo_valid (sdo_valid),
      .sdo_owner (sdo_owner),
      .busy      (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {8'h00, gnt0, done0, gnt1, done1, sdo, sdo_valid, sdo_owner, busy}, 16'h0000);
   endtask

   task automatic chk_idle(input string tag);
      tick();
      chk({tag, " busy"}, busy, 1'b0);
      chk({tag, " gnt"}, {gnt1, gnt0}, 2'b00);
      chk({tag, " valid"}, sdo_valid, 1'b0);
   endtask

   // Checks one whole frame; the request must already be presented.
   // drop_cyc: cycle in which owner's data/req are disturbed (0 = never).
   // drop_end: release owner's req once done has been seen.
   task automatic xfer(input logic who, input logic [W-1:0] word,
                       input int unsigned drop_cyc, input bit drop_end);
      logic [1:0] e_gnt, e_done, e_bit;
      for (int unsigned c = 1; c <= W + P + 1; c++) begin
         tick();
         e_gnt  = (c == 1) ? (who ? 2'b10 : 2'b01) : 2'b00;
         e_done = (c == W + P + 1) ? (who ? 2'b10 : 2'b01) : 2'b00;
         if (c <= W)                  e_bit = {1'b1, word[W-c]};
         else if (P == 1 && c == W+1) e_bit = {1'b1, ^word};
         else                         e_bit = 2'b00;
         chk($sformatf("gnt r%0d c%0d", who, c), {gnt1, gnt0}, e_gnt);
         chk($sformatf("done r%0d c%0d", who, c), {done1, done0}, e_done);
         chk($sformatf("valid_sdo r%0d c%0d", who, c), {sdo_valid, sdo}, e_bit);
         chk($sformatf("busy r%0d c%0d", who, c), busy, 1'b1);
         chk($sformatf("owner r%0d c%0d", who, c), sdo_owner, who);
         if (c == drop_cyc) begin
            if (who) begin data1 = '0; req1 = 1'b0; end
            else     begin data0 = '0; req0 = 1'b0; end
         end
         if (drop_end && c == W + P + 1) begin
            if (who) req1 = 1'b0;
            else     req0 = 1'b0;
         end
      end
   endtask

   initial begin
      logic [W-1:0] w5a;
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;

      // Reset state, before and across clock edges
      #2;
      chk_zero("reset async");
      tick(); chk_zero("reset edge1");
      tick(); chk_zero("reset edge2");

      // Release with no requests: stays idle
      rst_n = 1'b1;
      for (int unsigned i = 0; i < 3; i++) chk_idle("no req");

      // Single transfer, requester 0, A5
      data0 = 8'hA5; req0 = 1'b1;
      xfer(1'b0, 8'hA5, 0, 1'b1);
      chk_idle("after A5");

      // Input stability: data and req disturbed in cycle 3
      data0 = 8'hA5; req0 = 1'b1;
      xfer(1'b0, 8'hA5, 3, 1'b0);
      chk_idle("after stability");

      // Requester 1 alone, 07 (parity bit 1 when compiled in)
      data1 = 8'h07; req1 = 1'b1;
      xfer(1'b1, 8'h07, 0, 1'b1);
      chk_idle("after 07");

      // Contention from reset: 0,1,0,1 with one idle cycle between frames
      rst_n = 1'b0; #1; chk_zero("reset pre-contention");
      tick(); rst_n = 1'b1;
      data0 = 8'hA5; data1 = 8'h3C; req0 = 1'b1; req1 = 1'b1;
      xfer(1'b0, 8'hA5, 0, 1'b0); chk_idle("rr gap1");
      xfer(1'b1, 8'h3C, 0, 1'b0); chk_idle("rr gap2");
      xfer(1'b0, 8'hA5, 0, 1'b0); chk_idle("rr gap3");
      xfer(1'b1, 8'h3C, 0, 1'b1);
      req0 = 1'b0;
      chk_idle("rr end");
      chk_idle("rr end2");

      // Mid-transfer reset during cycle 4 of a requester 1 frame
      w5a = 8'h5A;
      data1 = w5a; req1 = 1'b1;
      for (int unsigned c = 1; c <= 4; c++) begin
         tick();
         chk($sformatf("midrst gnt1 c%0d", c), gnt1, (c == 1) ? 1'b1 : 1'b0);
         chk($sformatf("midrst valid_sdo c%0d", c), {sdo_valid, sdo}, {1'b1, w5a[W-c]});
      end
      rst_n = 1'b0;
      #1;
      chk_zero("midrst async");
      req1 = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int unsigned i = 0; i < W + P + 2; i++) begin
         tick();
         chk($sformatf("midrst no done i%0d", i), {done1, done0}, 2'b00);
         chk($sformatf("midrst idle i%0d", i), busy, 1'b0);
      end

      // After reset, last=1 so requester 0 wins the tie
      data0 = 8'hC3; data1 = 8'hFF; req0 = 1'b1; req1 = 1'b1;
      xfer(1'b0, 8'hC3, 0, 1'b1);
      chk_idle("post-rst gap");
      xfer(1'b1, 8'hFF, 0, 1'b1);
      chk_idle("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
